// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use hazard control for the pipelined datapath.
// Decodes the instruction entering IF/ID against the two instructions issued ahead of it.
module hazard_forward_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  output logic             stall,
  output logic             bubble,
  output logic             ex_forward_a,
  output logic             ex_forward_b,
  output logic             mem_forward_a,
  output logic             mem_forward_b,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [4:0] dest;
    logic       wr;
    logic       is_load;
  } hist_t;

  typedef struct packed {
    logic       reads_rs;
    logic       reads_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    hist_t      wb;
  } dec_t;

  typedef enum logic {
    RUN,
    LU_STALL
  } state_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    d    = '0;
    op   = ins[31:26];
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    case (op)
      6'h00: begin
        if (ins != '0) begin
          if (ins[5:0] == 6'h08) begin
            d.reads_rs = 1'b1;
          end else begin
            d.reads_rs = 1'b1;
            d.reads_rt = 1'b1;
            d.wb.dest  = ins[15:11];
            d.wb.wr    = 1'b1;
          end
        end
      end
      6'h08, 6'h09, 6'h0A: begin
        d.reads_rs = 1'b1;
        d.wb.dest  = ins[20:16];
        d.wb.wr    = 1'b1;
      end
      6'h23: begin
        d.reads_rs   = 1'b1;
        d.wb.dest    = ins[20:16];
        d.wb.wr      = 1'b1;
        d.wb.is_load = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        d.reads_rs = 1'b1;
        d.reads_rt = 1'b1;
      end
      default: begin
      end
    endcase
    if (d.wb.dest == 5'd0) begin
      d.wb = '0;
    end
    return d;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  hist_t            r_hist1;
  // The load flag is not kept two slots ahead: nothing downstream of hist1 consumes it.
  logic [4:0]       r_hist2_dest;
  logic             r_hist2_wr;
  logic [CNT_W-1:0] r_count;

  dec_t w_dec;
  logic w_ex_a;
  logic w_ex_b;
  logic w_mem_a;
  logic w_mem_b;
  logic w_hazard;

  always_comb begin
    w_dec   = decode(instr_in);
    w_ex_a  = w_dec.reads_rs & r_hist1.wr & (r_hist1.dest == w_dec.rs) & ~r_hist1.is_load;
    w_ex_b  = w_dec.reads_rt & r_hist1.wr & (r_hist1.dest == w_dec.rt) & ~r_hist1.is_load;
    w_mem_a = w_dec.reads_rs & r_hist2_wr & (r_hist2_dest == w_dec.rs) & ~w_ex_a;
    w_mem_b = w_dec.reads_rt & r_hist2_wr & (r_hist2_dest == w_dec.rt) & ~w_ex_b;
    w_hazard = r_hist1.is_load & r_hist1.wr &
               ((w_dec.reads_rs & (w_dec.rs == r_hist1.dest)) |
                (w_dec.reads_rt & (w_dec.rt == r_hist1.dest)));
  end

  always_comb begin
    w_next_state  = r_state;
    stall         = 1'b0;
    bubble        = 1'b0;
    ex_forward_a  = 1'b0;
    ex_forward_b  = 1'b0;
    mem_forward_a = 1'b0;
    mem_forward_b = 1'b0;
    case (r_state)
      RUN: begin
        if (!rst && instr_valid && w_hazard) begin
          stall        = 1'b1;
          bubble       = 1'b1;
          w_next_state = LU_STALL;
        end
      end
      LU_STALL: w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
    if (!rst && instr_valid && !stall) begin
      ex_forward_a  = w_ex_a;
      ex_forward_b  = w_ex_b;
      mem_forward_a = w_mem_a;
      mem_forward_b = w_mem_b;
    end
    stall_count = rst ? '0 : r_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_hist1      <= '0;
      r_hist2_dest <= '0;
      r_hist2_wr   <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_hist2_dest <= r_hist1.dest;
      r_hist2_wr   <= r_hist1.wr;
      r_hist1      <= (instr_valid && !stall) ? w_dec.wb : '0;
      if (stall && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Table-driven bench for hazard_forward_unit; a narrow stall counter exposes saturation.
module tb_hazard_forward_unit;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr_in;
  logic          instr_valid;
  logic          stall;
  logic          bubble;
  logic          ex_forward_a;
  logic          ex_forward_b;
  logic          mem_forward_a;
  logic          mem_forward_b;
  logic [CW-1:0] stall_count;

  hazard_forward_unit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .bubble       (bubble),
    .ex_forward_a (ex_forward_a),
    .ex_forward_b (ex_forward_b),
    .mem_forward_a(mem_forward_a),
    .mem_forward_b(mem_forward_b),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          st;
    logic          bu;
    logic          ea;
    logic          eb;
    logic          ma;
    logic          mb;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [31:0] ins;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   row    = 0;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] ins,
                              input logic st, input logic bu, input logic ea, input logic eb,
                              input logic ma, input logic mb, input int c);
    vec_t x;
    x.r   = r;
    x.v   = v;
    x.ins = ins;
    x.exp = '{st: st, bu: bu, ea: ea, eb: eb, ma: ma, mb: mb, cnt: CW'(c)};
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step(input vec_t x);
    out_t e;
    rst         = x.r;
    instr_valid = x.v;
    instr_in    = x.ins;
    sb.push_back(x.exp);
    @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL row %0d scoreboard: got empty queue expected entry", row);
    end else begin
      e = sb.pop_front();
      chk("stall",         int'(stall),         int'(e.st));
      chk("bubble",        int'(bubble),        int'(e.bu));
      chk("ex_forward_a",  int'(ex_forward_a),  int'(e.ea));
      chk("ex_forward_b",  int'(ex_forward_b),  int'(e.eb));
      chk("mem_forward_a", int'(mem_forward_a), int'(e.ma));
      chk("mem_forward_b", int'(mem_forward_b), int'(e.mb));
      chk("stall_count",   int'(stall_count),   int'(e.cnt));
    end
    row++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] add3, sub4, add8, or6, lw2, add4, addi0, add1, sub3, and7;
    logic [31:0] lw5, add6, jr3, sw3, beq3, nop;
    add3  = 32'h00221820;
    sub4  = 32'h00652022;
    add8  = rtype(9, 10, 8, 'h20);
    or6   = rtype(7, 3, 6, 'h25);
    lw2   = itype('h23, 1, 2, 0);
    add4  = rtype(2, 2, 4, 'h20);
    addi0 = itype('h08, 0, 0, 5);
    add1  = rtype(0, 0, 1, 'h20);
    sub3  = rtype(4, 5, 3, 'h22);
    and7  = rtype(3, 3, 7, 'h24);
    lw5   = itype('h23, 2, 5, 0);
    add6  = rtype(5, 0, 6, 'h20);
    jr3   = rtype(3, 0, 0, 'h08);
    sw3   = itype('h2B, 3, 3, 0);
    beq3  = itype('h04, 3, 0, 0);
    nop   = '0;

    //        rst   vld  instr  st bu ea eb ma mb cnt
    tbl.push_back(mk(1, 1, add3,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, nop,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, add3,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, sub4,  0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, add3,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, add8,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, or6,   0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, lw2,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, add4,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, add4,  0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, addi0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, add1,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, add3,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, sub3,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, and7,  0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, nop,   0, 0, 0, 0, 0, 0, 1));
    foreach (tbl[i]) step(tbl[i]);

    // Reset lands in the LU_STALL cycle; the re-presented add sees clean history.
    step(mk(0, 1, lw2,  0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 1, add4, 1, 1, 0, 0, 0, 0, 1));
    step(mk(1, 1, add4, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, add4, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 0));

    // lw feeding a dependent lw feeding an add: one stall per dependent pair.
    step(mk(0, 1, lw2,  0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, lw5,  1, 1, 0, 0, 0, 0, 0));
    step(mk(0, 1, lw5,  0, 0, 0, 0, 1, 0, 1));
    step(mk(0, 1, add6, 1, 1, 0, 0, 0, 0, 1));
    step(mk(0, 1, add6, 0, 0, 0, 0, 1, 0, 2));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 2));

    // A hazard on an invalid slot neither stalls nor counts.
    step(mk(0, 1, lw2,  0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 0, add4, 0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 2));

    // jr reads rs only and writes nothing; sw/beq read both.
    step(mk(0, 1, add3, 0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 1, jr3,  0, 0, 1, 0, 0, 0, 2));
    step(mk(0, 1, sw3,  0, 0, 0, 0, 1, 1, 2));
    step(mk(0, 1, beq3, 0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 2));

    // Counter reaches all-ones and then holds.
    step(mk(0, 1, lw2,  0, 0, 0, 0, 0, 0, 2));
    step(mk(0, 1, add4, 1, 1, 0, 0, 0, 0, 2));
    step(mk(0, 1, add4, 0, 0, 0, 0, 1, 1, 3));
    step(mk(0, 0, nop,  0, 0, 0, 0, 0, 0, 3));
    step(mk(0, 1, lw2,  0, 0, 0, 0, 0, 0, 3));
    step(mk(0, 1, add4, 1, 1, 0, 0, 0, 0, 3));
    step(mk(0, 1, add4, 0, 0, 0, 0, 1, 1, 3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_in    = '0;
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
